// File: rtl/nor_response_checker.sv
// Response-side checker for a NOR gate under test: derives the 0/1/x expected output
// and times how long the gate takes to present it. Define NOR_CHK_STABLE_EN to require two matching samples.
module nor_response_checker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             a_known,
    input  logic             b_known,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             expected,
    output logic             exp_known,
    output logic [CNT_W-1:0] delay,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             expected_q, expected_d;
    logic             exp_known_q, exp_known_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [7:0]       err_q, err_d;
`ifdef NOR_CHK_STABLE_EN
    logic             prev_q, prev_d;
    logic             ext_q, ext_d;
`endif

    logic any_one_c, both_zero_c, match_c;

    // A known 1 forces the NOR low; only two known 0s force it high.
    assign any_one_c   = (a_known & a) | (b_known & b);
    assign both_zero_c = a_known & b_known & ~a & ~b;
    assign match_c     = (y == expected_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        expected_d  = expected_q;
        exp_known_d = exp_known_q;
        delay_d     = delay_q;
        err_d       = err_q;
`ifdef NOR_CHK_STABLE_EN
        prev_d      = prev_q;
        ext_d       = ext_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    expected_d  = both_zero_c;
                    exp_known_d = any_one_c | both_zero_c;
                    cnt_d       = '0;
`ifdef NOR_CHK_STABLE_EN
                    prev_d      = 1'b0;
                    ext_d       = 1'b0;
`endif
                    if (any_one_c | both_zero_c) begin
                        state_d = WAIT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        delay_d = '0;
                    end
                end
            end
            WAIT: begin
`ifdef NOR_CHK_STABLE_EN
                // ext_q marks the extra sample that completes a pair starting at TIMEOUT.
                if (ext_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = match_c;
                    delay_d = TMO;
                    if (!match_c && err_q != 8'hFF) err_d = err_q + 8'd1;
                end else if (prev_q && match_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = 1'b1;
                    delay_d = cnt_q - CNT_W'(1);
                end else if (cnt_q == TMO) begin
                    if (match_c) begin
                        ext_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = 1'b0;
                        delay_d = TMO;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                end else begin
                    prev_d = match_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
`else
                if (match_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = 1'b1;
                    delay_d = cnt_q;
                end else if (cnt_q == TMO) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    delay_d = TMO;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            expected_q  <= 1'b0;
            exp_known_q <= 1'b0;
            delay_q     <= '0;
            err_q       <= '0;
`ifdef NOR_CHK_STABLE_EN
            prev_q      <= 1'b0;
            ext_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            expected_q  <= expected_d;
            exp_known_q <= exp_known_d;
            delay_q     <= delay_d;
            err_q       <= err_d;
`ifdef NOR_CHK_STABLE_EN
            prev_q      <= prev_d;
            ext_q       <= ext_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign expected  = expected_q;
    assign exp_known = exp_known_q;
    assign delay     = delay_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_nor_response_checker.sv
// Directed and randomized bench for nor_response_checker against a trace-search reference model.
module tb_nor_response_checker;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned T     = 10;

    logic clk = 1'b0;
    logic reset, start, a, b, a_known, b_known, y;
    logic busy, done, pass, expected, exp_known;
    logic [CNT_W-1:0] delay;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int model_err = 0;
    logic tr [0:T+3];

    nor_response_checker #(.CNT_W(CNT_W), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .a_known(a_known), .b_known(b_known), .y(y),
        .busy(busy), .done(done), .pass(pass), .expected(expected),
        .exp_known(exp_known), .delay(delay), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void nor_model(input logic va, vak, vb, vbk, output logic e, output logic ek);
        if ((vak && va) || (vbk && vb)) begin e = 1'b0; ek = 1'b1; end
        else if (vak && vbk)            begin e = 1'b1; ek = 1'b1; end
        else                            begin e = 1'b0; ek = 1'b0; end
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/busy"}, 32'(busy), 0);
        chk({tag, "/done"}, 32'(done), 0);
        chk({tag, "/pass"}, 32'(pass), 0);
        chk({tag, "/expected"}, 32'(expected), 0);
        chk({tag, "/exp_known"}, 32'(exp_known), 0);
        chk({tag, "/delay"}, 32'(delay), 0);
        chk({tag, "/err_count"}, 32'(err_count), 0);
    endtask

    task automatic run_vec(input string tag, input logic va, vak, vb, vbk, input bit mid_start);
        logic e, ek, ep;
        int ed, lat, cyc;
        bit got, found;
        nor_model(va, vak, vb, vbk, e, ek);
        found = 1'b0;
        ed = 0;
        if (!ek) begin
            ep = 1'b1; ed = 0; lat = 1;
        end else begin
            for (int k = 0; k <= int'(T); k++) begin
`ifdef NOR_CHK_STABLE_EN
                if (!found && tr[k] == e && tr[k+1] == e) begin found = 1'b1; ed = k; end
`else
                if (!found && tr[k] == e) begin found = 1'b1; ed = k; end
`endif
            end
`ifdef NOR_CHK_STABLE_EN
            if (found) begin ep = 1'b1; lat = ed + 3; end
            else begin ep = 1'b0; ed = int'(T); lat = int'(T) + 2 + ((tr[T] == e) ? 1 : 0); end
`else
            if (found) begin ep = 1'b1; lat = ed + 2; end
            else begin ep = 1'b0; ed = int'(T); lat = int'(T) + 2; end
`endif
            if (!found && model_err < 255) model_err++;
        end

        @(negedge clk);
        a = va; a_known = vak; b = vb; b_known = vbk; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        y = tr[0];
        cyc = 1;
        got = 1'b0;
        while (cyc <= int'(T) + 4 && !got) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                chk({tag, "/busy_wait"}, 32'(busy), 32'(ek));
                @(posedge clk); #1;
                y = (cyc <= int'(T) + 3) ? tr[cyc] : 1'b0;
                start = mid_start && (cyc == 2);
                if (mid_start) begin a = 1'b0; b = 1'b0; a_known = 1'b1; b_known = 1'b1; end
                cyc++;
            end
        end
        chk({tag, "/latency"}, got ? 32'(cyc) : 32'(0), 32'(lat));
        if (got) begin
            chk({tag, "/exp_known"}, 32'(exp_known), 32'(ek));
            if (ek) chk({tag, "/expected"}, 32'(expected), 32'(e));
            chk({tag, "/pass"}, 32'(pass), 32'(ep));
            chk({tag, "/delay"}, 32'(delay), 32'(ed));
            chk({tag, "/err_count"}, 32'(err_count), 32'(model_err));
            chk({tag, "/busy_done"}, 32'(busy), 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "/done_low"}, 32'(done), 0);
            chk({tag, "/pass_hold"}, 32'(pass), 32'(ep));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic e, ek;
        int cyc;
        reset = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0;
        a_known = 1'b0; b_known = 1'b0; y = 1'b0;
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;

        // a=0 known, b=x: expected x, result immediately
        run_vec("x_vec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // a=1, b=x, y held 0: match at k=0
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = 1'b0;
        run_vec("a1_bx", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // a=0, b=0, y high from k=5
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = (i >= 5);
`ifdef NOR_CHK_STABLE_EN
        tr[2] = 1'b1;
`endif
        run_vec("a0_b0_d5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // a=1, b=1, y stuck 1: timeout
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = 1'b1;
        run_vec("stuck1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // second start during WAIT is ignored
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = (i < 6);
        run_vec("mid_start", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // reset at k=3 of WAIT aborts without done
        @(negedge clk);
        a = 1'b0; b = 1'b0; a_known = 1'b1; b_known = 1'b1; start = 1'b1; y = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 4; cyc++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("abort/busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;
        model_err = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort/no_done", 32'(done), 0);
        end
        @(posedge clk); #1;
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = (i >= 2);
        run_vec("after_abort", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // randomized vectors and y traces
        for (int n = 0; n < 40; n++) begin
            logic ra, rb, rak, rbk;
            ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
            rak = ($urandom_range(0, 3) != 0); rbk = ($urandom_range(0, 3) != 0);
            nor_model(ra, rak, rb, rbk, e, ek);
            for (int i = 0; i <= int'(T) + 3; i++)
                tr[i] = ($urandom_range(0, 3) == 0) ? e : ~e;
            run_vec("rand", ra, rak, rb, rbk, 1'b0);
        end

        // error counter saturation
        for (int i = 0; i <= int'(T) + 3; i++) tr[i] = 1'b1;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            a = 1'b1; b = 1'b1; a_known = 1'b1; b_known = 1'b1; start = 1'b1; y = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 0;
            while (!done && cyc < int'(T) + 6) begin
                @(negedge clk);
                cyc++;
            end
            if (model_err < 255) model_err++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sat/err_count", 32'(err_count), 32'(model_err));
        chk("sat/err_255", 32'(err_count), 255);
        chk("sat/pass", 32'(pass), 0);
        chk("sat/delay", 32'(delay), 32'(T));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nor_response_checker.md
# nor_response_checker

Sequential checker that receives a NOR-gate stimulus vector, computes the expected output under 0/1/x rules, and measures how many clock cycles the gate under test takes to present that value. It sits on the response side of the gate test rig: the stimulus generator drives the gate and pulses `start`, and this block observes `y` and reports pass/fail, measured delay and a running error count.

## Interface
Parameters:
- `CNT_W`, 8: width of the delay counter and `delay` output.
- `TIMEOUT`, 200: cycles waited for a match before declaring failure; must be ≤ 2^CNT_W − 1.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: new vector applied to the gate; ignored unless idle.
- `a`, `b`  in  1 each  stimulus values, sampled with `start`.
- `a_known`, `b_known`  in  1 each  1 = input is a defined 0/1; 0 = input is x.
- `y`  in  1  gate output, already synchronous to `clk`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle result pulse.
- `pass`  out  1  result of last check; valid with and after `done`.
- `expected`  out  1  expected value of last vector; `exp_known` qualifies it.
- `exp_known`  out  1  0 = expected output is x (no check made).
- `delay`  out  CNT_W  cycles from start to match, or `TIMEOUT` on failure.
- `err_count`  out  8  failures since reset; saturates at 255.

## Operation
- Expected value:
  - any known input = 1 → 0, known;
  - both inputs known and 0 → 1, known;
  - otherwise x: `exp_known`=0.
- States: IDLE, WAIT, DONE.
- IDLE: `start`=1 latches the inputs and the expected value into `expected`/`exp_known`.
  - Known expected value → WAIT, counter cleared to 0.
  - x expected value → DONE with `pass`=1, `delay`=0.
- WAIT, k-th cycle (k=0 is the first cycle after `start`): sample `y`.
  - `y`==`expected` → DONE, `delay`=k, `pass`=1.
  - k reaches `TIMEOUT` with no match → DONE, `delay`=`TIMEOUT`, `pass`=0, `err_count`+1 (saturating).
- DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE. `start` in DONE is ignored.
- A `y` that already equals the expected value at k=0 gives `delay`=0.
- `start` while WAIT or DONE: ignored; latched vector is unchanged.

## Timing
- All outputs registered. Reset values: `busy`=0, `done`=0, `pass`=0, `expected`=0, `exp_known`=0, `delay`=0, `err_count`=0; state IDLE.
- Minimum latency, `start` to `done`:
  - 1 cycle for an x vector;
  - 2 cycles for a match at k=0.
- Maximum latency: `TIMEOUT`+2 cycles.
- Back-to-back: a new `start` is accepted on the cycle after `done`.
- `pass`, `delay`, `expected` and `exp_known` hold until the next result.
- `reset` mid-WAIT aborts immediately: no `done` pulse, `err_count` cleared.
- Counter never wraps: it stops at `TIMEOUT`.

## Configuration
- `NOR_CHK_STABLE_EN` defined: a match requires `y`==`expected` on two consecutive WAIT samples. `delay` reports the first sample of the pair. A single-cycle glitch to the expected value does not pass. Timeout applies to the first-sample index, so the maximum latency becomes `TIMEOUT`+3.
- Undefined: a single matching sample passes.

## Test plan
- a=0, b=x (`b_known`=0), `start` → `done` 1 cycle later, `exp_known`=0, `pass`=1, `delay`=0, `err_count`=0.
- a=1, b=x, `y` held 0 → `expected`=0, `exp_known`=1, `pass`=1, `delay`=0, `done` 2 cycles after `start`.
- a=0, b=0, `y` rises 5 cycles after `start` → `expected`=1, `pass`=1, `delay`=5; with `NOR_CHK_STABLE_EN`, `y` pulsed high at k=2 for one cycle then high from k=5 → `delay`=5.
- a=1, b=1, `y` stuck 1, `TIMEOUT`=10 → `pass`=0, `delay`=10, `err_count`=1. Repeated 256 times → `err_count`=255.
- Second `start` during WAIT (a=0, b=0 after a=1, b=0) → ignored, `expected` stays 0, one `done` only.
- `reset` asserted at k=3 of WAIT → no `done`, all outputs at reset values, next `start` accepted normally.
